// File: rtl/glb_strm_sched.sv
// Per-tile stream launch/completion scheduler: one FSM per GLB stream group,
// round-robin launch arbitration, completion tracking, sticky error flags.
module glb_strm_sched #(
  parameter int NUM_GROUP     = 4,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_GROUP-1:0]     start_req,
  input  logic [NUM_GROUP-1:0]     cfg_f2g_en,
  input  logic [NUM_GROUP-1:0]     cfg_g2f_en,
  input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
  input  logic [NUM_GROUP-1:0]     strm_f2g_interrupt,
  input  logic [NUM_GROUP-1:0]     strm_g2f_interrupt,
  input  logic [NUM_GROUP-1:0]     done_clr,
  output logic [NUM_GROUP-1:0]     strm_start_pulse,
  output logic [NUM_GROUP-1:0]     done_irq,
  output logic [NUM_GROUP-1:0]     busy,
  output logic [NUM_GROUP-1:0]     start_err,
  output logic [NUM_GROUP-1:0]     timeout_err,
  output logic [2*NUM_GROUP-1:0]   dbg_state
);

  // Handshake: start_req and done_clr are single-cycle pulses with no
  // back-pressure; a start is accepted only in IDLE (or DONE together with
  // done_clr), otherwise it is dropped and flagged in start_err.
  localparam int PTR_W = (NUM_GROUP > 1) ? $clog2(NUM_GROUP) : 1;
  localparam logic [PTR_W:0]           NG_W     = (PTR_W+1)'(NUM_GROUP);
  localparam logic [PTR_W-1:0]         PTR_LAST = PTR_W'(NUM_GROUP - 1);
  localparam logic [PTR_W-1:0]         PTR_ONE  = PTR_W'(1);
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_ONE  = TIMEOUT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                   state_q [NUM_GROUP];
  state_e                   state_d [NUM_GROUP];
  logic [TIMEOUT_WIDTH-1:0] cnt_q   [NUM_GROUP];
  logic [TIMEOUT_WIDTH-1:0] cnt_d   [NUM_GROUP];

  logic [NUM_GROUP-1:0] seen_f2g_q, seen_f2g_d, seen_g2f_q, seen_g2f_d;
  logic [NUM_GROUP-1:0] pulse_q, pulse_d, done_q, done_d, busy_q, busy_d;
  logic [NUM_GROUP-1:0] serr_q, serr_d, terr_q, terr_d;
  logic [NUM_GROUP-1:0] pend, grant_oh, run_done, tmo;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d, grant_idx;
  logic [PTR_W:0]       cand;
  logic                 grant_vld;

  // Interrupts arriving in the checking cycle itself count toward completion.
  assign run_done = (seen_f2g_q | strm_f2g_interrupt | ~cfg_f2g_en) &
                    (seen_g2f_q | strm_g2f_interrupt | ~cfg_g2f_en);

  always_comb begin
    pend = '0;
    tmo  = '0;
    for (int g = 0; g < NUM_GROUP; g++) begin
      pend[g] = (state_q[g] == S_PEND);
      tmo[g]  = (cfg_timeout != '0) && ((cnt_q[g] + CNT_ONE) == cfg_timeout);
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    cand      = '0;
    rr_ptr_d  = rr_ptr_q;
    for (int i = 0; i < NUM_GROUP; i++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (cand >= NG_W) cand = cand - NG_W;
      if (!grant_vld && pend[cand[PTR_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[PTR_W-1:0];
      end
    end
    if (grant_vld) begin
      grant_oh[grant_idx] = 1'b1;
      rr_ptr_d = (grant_idx == PTR_LAST) ? '0 : grant_idx + PTR_ONE;
    end
  end

  always_comb begin
    seen_f2g_d = seen_f2g_q;
    seen_g2f_d = seen_g2f_q;
    serr_d     = serr_q;
    terr_d     = terr_q;
    pulse_d    = '0;
    done_d     = '0;
    busy_d     = '0;
    for (int g = 0; g < NUM_GROUP; g++) begin
      state_d[g] = state_q[g];
      cnt_d[g]   = cnt_q[g];
      case (state_q[g])
        S_IDLE: if (start_req[g]) state_d[g] = S_PEND;
        S_PEND: begin
          if (start_req[g]) serr_d[g] = 1'b1;
          if (grant_oh[g]) begin
            state_d[g]    = S_RUN;
            pulse_d[g]    = 1'b1;
            seen_f2g_d[g] = 1'b0;
            seen_g2f_d[g] = 1'b0;
            cnt_d[g]      = '0;
          end
        end
        S_RUN: begin
          if (start_req[g]) serr_d[g] = 1'b1;
          seen_f2g_d[g] = seen_f2g_q[g] | strm_f2g_interrupt[g];
          seen_g2f_d[g] = seen_g2f_q[g] | strm_g2f_interrupt[g];
          cnt_d[g]      = cnt_q[g] + CNT_ONE;
          if (run_done[g]) begin
            state_d[g] = S_DONE;
          end else if (tmo[g]) begin
            state_d[g] = S_DONE;
            terr_d[g]  = 1'b1;
          end
        end
        S_DONE: begin
          if (done_clr[g]) begin
            state_d[g]    = start_req[g] ? S_PEND : S_IDLE;
            serr_d[g]     = 1'b0;
            terr_d[g]     = 1'b0;
            seen_f2g_d[g] = 1'b0;
            seen_g2f_d[g] = 1'b0;
            cnt_d[g]      = '0;
          end else if (start_req[g]) begin
            serr_d[g] = 1'b1;
          end
        end
        default: state_d[g] = S_IDLE;
      endcase
      done_d[g] = (state_d[g] == S_DONE);
      busy_d[g] = (state_d[g] != S_IDLE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int g = 0; g < NUM_GROUP; g++) begin
        state_q[g] <= S_IDLE;
        cnt_q[g]   <= '0;
      end
      seen_f2g_q <= '0;
      seen_g2f_q <= '0;
      pulse_q    <= '0;
      done_q     <= '0;
      busy_q     <= '0;
      serr_q     <= '0;
      terr_q     <= '0;
      rr_ptr_q   <= '0;
    end else begin
      for (int g = 0; g < NUM_GROUP; g++) begin
        state_q[g] <= state_d[g];
        cnt_q[g]   <= cnt_d[g];
      end
      seen_f2g_q <= seen_f2g_d;
      seen_g2f_q <= seen_g2f_d;
      pulse_q    <= pulse_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      serr_q     <= serr_d;
      terr_q     <= terr_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  always_comb begin
    dbg_state = '0;
    for (int g = 0; g < NUM_GROUP; g++) dbg_state[2*g +: 2] = state_q[g];
  end

  assign strm_start_pulse = pulse_q;
  assign done_irq         = done_q;
  assign busy             = busy_q;
  assign start_err        = serr_q;
  assign timeout_err      = terr_q;

endmodule

// File: tb/tb_glb_strm_sched.sv
// Bench for glb_strm_sched: directed scenarios with fixed expectations plus
// randomized traffic against a cycle-level behavioural model.
module tb_glb_strm_sched;
  localparam int NG = 4;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [NG-1:0] start_req, cfg_f2g_en, cfg_g2f_en;
  logic [TW-1:0] cfg_timeout;
  logic [NG-1:0] strm_f2g_interrupt, strm_g2f_interrupt, done_clr;
  logic [NG-1:0] strm_start_pulse, done_irq, busy, start_err, timeout_err;
  logic [2*NG-1:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  glb_strm_sched #(.NUM_GROUP(NG), .TIMEOUT_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .start_req(start_req),
    .cfg_f2g_en(cfg_f2g_en), .cfg_g2f_en(cfg_g2f_en), .cfg_timeout(cfg_timeout),
    .strm_f2g_interrupt(strm_f2g_interrupt), .strm_g2f_interrupt(strm_g2f_interrupt),
    .done_clr(done_clr), .strm_start_pulse(strm_start_pulse), .done_irq(done_irq),
    .busy(busy), .start_err(start_err), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit   m_wait[NG], m_run[NG], m_fin[NG], m_sf[NG], m_sg[NG], m_serr[NG], m_terr[NG];
  int   m_len[NG];
  int   m_ptr;
  logic [NG-1:0] m_pulse;

  task automatic mdl_reset();
    for (int g = 0; g < NG; g++) begin
      m_wait[g] = 0; m_run[g] = 0; m_fin[g] = 0; m_sf[g] = 0; m_sg[g] = 0;
      m_serr[g] = 0; m_terr[g] = 0; m_len[g] = 0;
    end
    m_ptr = 0;
    m_pulse = '0;
  endtask

  task automatic mdl_step();
    int gsel;
    gsel = -1;
    for (int k = 0; k < NG; k++) begin
      int g;
      g = (m_ptr + k) % NG;
      if (gsel < 0 && m_wait[g]) gsel = g;
    end
    m_pulse = '0;
    for (int g = 0; g < NG; g++) begin
      if (m_fin[g]) begin
        if (done_clr[g]) begin
          m_fin[g] = 0; m_serr[g] = 0; m_terr[g] = 0;
          if (start_req[g]) m_wait[g] = 1;
        end else if (start_req[g]) m_serr[g] = 1;
      end else if (m_run[g]) begin
        if (start_req[g]) m_serr[g] = 1;
        m_sf[g] = m_sf[g] | strm_f2g_interrupt[g];
        m_sg[g] = m_sg[g] | strm_g2f_interrupt[g];
        m_len[g]++;
        if ((m_sf[g] || !cfg_f2g_en[g]) && (m_sg[g] || !cfg_g2f_en[g])) begin
          m_run[g] = 0; m_fin[g] = 1;
        end else if (cfg_timeout != 0 && m_len[g] == int'(cfg_timeout)) begin
          m_run[g] = 0; m_fin[g] = 1; m_terr[g] = 1;
        end
      end else if (m_wait[g]) begin
        if (start_req[g]) m_serr[g] = 1;
        if (g == gsel) begin
          m_wait[g] = 0; m_run[g] = 1; m_len[g] = 0; m_sf[g] = 0; m_sg[g] = 0;
          m_pulse[g] = 1'b1;
        end
      end else if (start_req[g]) m_wait[g] = 1;
    end
    if (gsel >= 0) m_ptr = (gsel + 1) % NG;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start_req = '0; strm_f2g_interrupt = '0; strm_g2f_interrupt = '0; done_clr = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    cfg_f2g_en = '1; cfg_g2f_en = '1; cfg_timeout = '0;
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    mdl_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++; if (strm_start_pulse !== 4'b0) begin n_err++; $display("FAIL reset_pulse got=%b exp=0000", strm_start_pulse); end
    n_cmp++; if (done_irq !== 4'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0000", done_irq); end
    n_cmp++; if (busy !== 4'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0000", busy); end
    n_cmp++; if (start_err !== 4'b0) begin n_err++; $display("FAIL reset_serr got=%b exp=0000", start_err); end
    n_cmp++; if (timeout_err !== 4'b0) begin n_err++; $display("FAIL reset_terr got=%b exp=0000", timeout_err); end
  endtask

  task automatic test_basic_launch();
    logic [NG-1:0] ep, ed, eb;
    do_reset();
    for (int k = 0; k <= 21; k++) begin
      clear_inputs();
      start_req[1] = (k == 0);
      strm_f2g_interrupt[1] = (k == 10);
      strm_g2f_interrupt[1] = (k == 15);
      done_clr[1] = (k == 20);
      ep = (k == 2) ? 4'b0010 : 4'b0000;
      ed = (k >= 16 && k <= 20) ? 4'b0010 : 4'b0000;
      eb = (k >= 1 && k <= 20) ? 4'b0010 : 4'b0000;
      n_cmp++; if (strm_start_pulse !== ep) begin n_err++; $display("FAIL basic_pulse k=%0d got=%b exp=%b", k, strm_start_pulse, ep); end
      n_cmp++; if (done_irq !== ed) begin n_err++; $display("FAIL basic_done k=%0d got=%b exp=%b", k, done_irq, ed); end
      n_cmp++; if (busy !== eb) begin n_err++; $display("FAIL basic_busy k=%0d got=%b exp=%b", k, busy, eb); end
      tick();
    end
  endtask

  task automatic test_arbitration();
    logic [NG-1:0] ep, ed;
    do_reset();
    cfg_f2g_en = '0; cfg_g2f_en = '0;
    for (int k = 0; k <= 15; k++) begin
      clear_inputs();
      start_req = (k == 0) ? 4'b1111 : (k == 10) ? 4'b1001 : 4'b0000;
      done_clr  = (k == 8) ? 4'b1111 : (k == 15) ? 4'b1001 : 4'b0000;
      ep = '0;
      if (k >= 2 && k <= 5) ep[k-2] = 1'b1;
      if (k == 12) ep = 4'b0001;
      if (k == 13) ep = 4'b1000;
      ed[0] = (k >= 3 && k <= 8) || (k >= 13);
      ed[1] = (k >= 4 && k <= 8);
      ed[2] = (k >= 5 && k <= 8);
      ed[3] = (k >= 6 && k <= 8) || (k >= 14);
      n_cmp++; if (strm_start_pulse !== ep) begin n_err++; $display("FAIL arb_pulse k=%0d got=%b exp=%b", k, strm_start_pulse, ep); end
      n_cmp++; if (done_irq !== ed) begin n_err++; $display("FAIL arb_done k=%0d got=%b exp=%b", k, done_irq, ed); end
      n_cmp++; if (start_err !== 4'b0) begin n_err++; $display("FAIL arb_serr k=%0d got=%b exp=0000", k, start_err); end
      tick();
    end
  endtask

  task automatic test_timeout();
    logic [NG-1:0] ed;
    do_reset();
    cfg_timeout = 16'd8;
    for (int k = 0; k <= 15; k++) begin
      clear_inputs();
      start_req[2] = (k == 0);
      strm_f2g_interrupt[2] = (k == 4);
      done_clr[2] = (k == 13);
      ed = (k >= 10 && k <= 13) ? 4'b0100 : 4'b0000;
      n_cmp++; if (done_irq !== ed) begin n_err++; $display("FAIL tmo_done k=%0d got=%b exp=%b", k, done_irq, ed); end
      n_cmp++; if (timeout_err !== ed) begin n_err++; $display("FAIL tmo_err k=%0d got=%b exp=%b", k, timeout_err, ed); end
      tick();
    end
  endtask

  task automatic test_timeout_tie();
    logic [NG-1:0] ed;
    do_reset();
    cfg_timeout = 16'd8;
    for (int k = 0; k <= 12; k++) begin
      clear_inputs();
      start_req[0] = (k == 0);
      strm_f2g_interrupt[0] = (k == 4);
      strm_g2f_interrupt[0] = (k == 9);
      ed = (k >= 10) ? 4'b0001 : 4'b0000;
      n_cmp++; if (done_irq !== ed) begin n_err++; $display("FAIL tie_done k=%0d got=%b exp=%b", k, done_irq, ed); end
      n_cmp++; if (timeout_err !== 4'b0) begin n_err++; $display("FAIL tie_terr k=%0d got=%b exp=0000", k, timeout_err); end
      tick();
    end
  endtask

  task automatic test_errors();
    logic [NG-1:0] ep, ed, es;
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      clear_inputs();
      start_req[2] = (k == 0) || (k == 5) || (k == 12);
      strm_f2g_interrupt[2] = (k == 7);
      strm_g2f_interrupt[2] = (k == 8);
      done_clr[2] = (k == 12);
      ep = (k == 2 || k == 14) ? 4'b0100 : 4'b0000;
      ed = (k >= 9 && k <= 12) ? 4'b0100 : 4'b0000;
      es = (k >= 6 && k <= 12) ? 4'b0100 : 4'b0000;
      n_cmp++; if (strm_start_pulse !== ep) begin n_err++; $display("FAIL err_pulse k=%0d got=%b exp=%b", k, strm_start_pulse, ep); end
      n_cmp++; if (done_irq !== ed) begin n_err++; $display("FAIL err_done k=%0d got=%b exp=%b", k, done_irq, ed); end
      n_cmp++; if (start_err !== es) begin n_err++; $display("FAIL err_serr k=%0d got=%b exp=%b", k, start_err, es); end
      tick();
    end
  endtask

  task automatic test_zero_enable();
    logic [NG-1:0] ep, ed;
    do_reset();
    cfg_f2g_en = '0; cfg_g2f_en = '0;
    for (int k = 0; k <= 5; k++) begin
      clear_inputs();
      start_req[3] = (k == 0);
      ep = (k == 2) ? 4'b1000 : 4'b0000;
      ed = (k >= 3) ? 4'b1000 : 4'b0000;
      n_cmp++; if (strm_start_pulse !== ep) begin n_err++; $display("FAIL zen_pulse k=%0d got=%b exp=%b", k, strm_start_pulse, ep); end
      n_cmp++; if (done_irq !== ed) begin n_err++; $display("FAIL zen_done k=%0d got=%b exp=%b", k, done_irq, ed); end
      tick();
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    start_req[0] = 1'b1;
    tick();
    clear_inputs();
    repeat (3) tick();
    n_cmp++; if (busy !== 4'b0001) begin n_err++; $display("FAIL rst_busy_pre got=%b exp=0001", busy); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (busy !== 4'b0) begin n_err++; $display("FAIL rst_busy_async got=%b exp=0000", busy); end
    n_cmp++; if (strm_start_pulse !== 4'b0 || done_irq !== 4'b0) begin
      n_err++; $display("FAIL rst_out_async got=%b/%b exp=0000/0000", strm_start_pulse, done_irq);
    end
    tick(); tick();
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      strm_f2g_interrupt = (k == 3) ? 4'b1111 : 4'b0000;
      strm_g2f_interrupt = (k == 3) ? 4'b1111 : 4'b0000;
      n_cmp++; if (strm_start_pulse !== 4'b0) begin n_err++; $display("FAIL rst_post_pulse k=%0d got=%b exp=0000", k, strm_start_pulse); end
      n_cmp++; if (done_irq !== 4'b0 || busy !== 4'b0) begin
        n_err++; $display("FAIL rst_post_state k=%0d got=%b/%b exp=0000/0000", k, done_irq, busy);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_random();
    logic [NG-1:0] ed, eb, es, et;
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      cfg_f2g_en = NG'($urandom);
      cfg_g2f_en = NG'($urandom);
      cfg_timeout = ($urandom_range(0, 3) == 0) ? 16'd0 : TW'($urandom_range(1, 12));
      for (int c = 0; c < 400; c++) begin
        for (int g = 0; g < NG; g++) begin
          start_req[g]          = ($urandom_range(0, 5) == 0);
          strm_f2g_interrupt[g] = ($urandom_range(0, 4) == 0);
          strm_g2f_interrupt[g] = ($urandom_range(0, 4) == 0);
          done_clr[g]           = ($urandom_range(0, 3) == 0);
          ed[g] = m_fin[g];
          eb[g] = m_wait[g] | m_run[g] | m_fin[g];
          es[g] = m_serr[g];
          et[g] = m_terr[g];
        end
        n_cmp++; if (strm_start_pulse !== m_pulse) begin n_err++; $display("FAIL rnd_pulse seg=%0d c=%0d got=%b exp=%b", seg, c, strm_start_pulse, m_pulse); end
        n_cmp++; if (done_irq !== ed) begin n_err++; $display("FAIL rnd_done seg=%0d c=%0d got=%b exp=%b", seg, c, done_irq, ed); end
        n_cmp++; if (busy !== eb) begin n_err++; $display("FAIL rnd_busy seg=%0d c=%0d got=%b exp=%b", seg, c, busy, eb); end
        n_cmp++; if (start_err !== es) begin n_err++; $display("FAIL rnd_serr seg=%0d c=%0d got=%b exp=%b", seg, c, start_err, es); end
        n_cmp++; if (timeout_err !== et) begin n_err++; $display("FAIL rnd_terr seg=%0d c=%0d got=%b exp=%b", seg, c, timeout_err, et); end
        mdl_step();
        tick();
      end
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    cfg_f2g_en = '1; cfg_g2f_en = '1; cfg_timeout = '0;
    test_reset();
    test_basic_launch();
    test_arbitration();
    test_timeout();
    test_timeout_tie();
    test_errors();
    test_zero_enable();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/glb_strm_sched.md
Name: glb_strm_sched

Overview:
- Per-tile stream launch and completion scheduler for the global buffer streaming path.
- Accepts start requests from the config/processor side for NUM_GROUP GLB stream groups.
- Serialises the resulting strm_start_pulse launches with a round-robin arbiter, at most one launch per cycle.
- Tracks the f2g/g2f completion interrupts of each group and raises a per-group done interrupt. Also flags errors and timeouts.

Parameters:
- NUM_GROUP, 4, number of independent stream groups (GLB tiles) scheduled.
- TIMEOUT_WIDTH, 16, width of the per-group run timeout counter and cfg_timeout.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- start_req  input  NUM_GROUP  one-cycle start request per group.
- cfg_f2g_en  input  NUM_GROUP  group expects strm_f2g_interrupt.
- cfg_g2f_en  input  NUM_GROUP  group expects strm_g2f_interrupt.
- cfg_timeout  input  TIMEOUT_WIDTH  max RUN cycles; 0 disables the timeout.
- strm_f2g_interrupt  input  NUM_GROUP  completion pulse from the datapath, f2g direction.
- strm_g2f_interrupt  input  NUM_GROUP  completion pulse from the datapath, g2f direction.
- done_clr  input  NUM_GROUP  acknowledge; clears done_irq and the error bits of that group.
- strm_start_pulse  output  NUM_GROUP  registered one-cycle launch pulse to the datapath.
- done_irq  output  NUM_GROUP  level interrupt; group finished.
- busy  output  NUM_GROUP  group pending, running or done-not-cleared.
- start_err  output  NUM_GROUP  sticky; a start_req was dropped.
- timeout_err  output  NUM_GROUP  sticky; the group finished by timeout.

Behaviour:
- Reset (asynchronous, reset=0): all outputs 0, all group FSMs IDLE, pending=0, seen flags=0, counters=0, rr_ptr=0. Reset mid-run aborts silently; no pulse is generated after release.
- Per-group FSM states: IDLE, PEND, RUN, DONE.
- IDLE, start_req=1: go to PEND.
- PEND, group granted: go to RUN. strm_start_pulse[g]=1 for exactly the cycle the group enters RUN.
- RUN: seen_f2g / seen_g2f latch the corresponding interrupt bits, sampled only in RUN, including the pulse cycle.
- RUN completion condition: (seen_f2g | ~cfg_f2g_en) & (seen_g2f | ~cfg_g2f_en). When true, go to DONE on the next edge.
  - Both enables 0: the group completes in the cycle after the pulse.
  - Interrupt arrives in the same cycle as the completion check: counted.
- Timeout: the counter increments each RUN cycle. When cfg_timeout != 0 and the count reaches cfg_timeout before completion, go to DONE and set timeout_err[g]. If completion and timeout occur in the same cycle, completion wins and timeout_err stays 0.
- DONE: done_irq[g]=1. done_clr[g] returns the group to IDLE, clears timeout_err[g], start_err[g], seen flags and counter.
- Dropped starts: start_req in PEND, RUN, or in DONE without done_clr is ignored and sets start_err[g].
- DONE with start_req and done_clr in the same cycle: the clear is taken, the request is accepted, and the group goes directly to PEND.
- Interrupts arriving in IDLE, PEND or DONE are ignored.
- Arbiter: among PEND groups, grant the first at or after rr_ptr (modulo NUM_GROUP). After a grant, rr_ptr = granted+1 (wraps NUM_GROUP-1 -> 0). With no PEND group, rr_ptr holds.
- Latency: an uncontested start_req high in cycle t gives strm_start_pulse in cycle t+2. The PEND register is set at end of t; the pulse register is set at end of t+1.
- busy[g] = (state != IDLE).
- done_irq, busy, start_err and timeout_err are all registered.
- Config inputs are sampled live. They must be held stable while a group is in RUN; this is the software contract.

Test Plan:
- Basic launch (group1, both enables=1, cfg_timeout=0): start_req[1] in cycle 10 -> strm_start_pulse=4'b0010 in cycle 12 only. f2g in cycle 20, g2f in cycle 25 -> done_irq[1]=1 from cycle 26. done_clr in cycle 30 -> done_irq=0 and busy[1]=0 from cycle 31.
- Arbitration: start_req=4'b1111 in cycle t after reset -> pulses 0001, 0010, 0100, 1000 in cycles t+2..t+5. A following start_req=4'b1001 after all cleared (rr_ptr=0) -> group0 then group3.
- Timeout (cfg_timeout=8, g2f never arrives, f2g arrives): done_irq and timeout_err for the group asserted after exactly 8 RUN cycles. done_clr clears both.
- Errors: start_req[2] while group2 is in RUN -> no pulse, start_err[2]=1; the run completes normally. Simultaneous done_clr + start_req in DONE -> new pulse 2 cycles later, start_err=0.
- Zero-enable: cfg_f2g_en=cfg_g2f_en=0 -> done_irq one cycle after the pulse.
- Reset: assert reset in RUN -> all outputs 0 immediately (asynchronous). After release, no pulse and no done without a new start_req.
